sram_req_adapter: RTL and testbench
===================================

// Module: sram_req_adapter
// PURPOSE
//  Bridges a core-side valid/ready request channel onto one port of the 1rw SRAM macro
//  (ram_generic_1rw: csb/web/wmask/addr/din/dout) and returns read data on a valid/ready
//  response channel. Tracks in-flight reads across the macro's fixed read latency.
//  Buffers returned data in a small response FIFO and throttles requests by credit so no
//  read data is ever dropped. Sits directly upstream of the SRAM macro.
// PARAMETERS
//  DATA_WIDTH  32   data width; must equal 8*NUM_WMASKS
//  ADDR_WIDTH  9    word address width (512 words)
//  NUM_WMASKS  4    byte write-mask bits
//  READ_LAT    1    posedges from macro read capture to dout valid-to-sample (1..4)
//  RSP_DEPTH   2    response FIFO entries (2..8, power of two not required)
// PORTS
//  clk        in   1            single clock; macro shares it
//  rst        in   1            synchronous, active-high reset
//  req_valid  in   1            request present
//  req_ready  out  1            request accepted on posedge when valid&ready
//  req_we     in   1            1=write (no response), 0=read
//  req_wmask  in   NUM_WMASKS   byte enables, writes only
//  req_addr   in   ADDR_WIDTH   word address
//  req_wdata  in   DATA_WIDTH   write data
//  rsp_valid  out  1            read data available
//  rsp_ready  in   1            consumer takes rsp_rdata on posedge when valid&ready
//  rsp_rdata  out  DATA_WIDTH   read data, in request order
//  csb        out  1            macro chip select, active low
//  web        out  1            macro write enable, active low
//  wmask      out  NUM_WMASKS   macro byte mask
//  addr       out  ADDR_WIDTH   macro address
//  din        out  DATA_WIDTH   macro write data
//  dout       in   DATA_WIDTH   macro read data
// BEHAVIOUR
//  - fire = req_valid & req_ready. Macro signals driven combinationally from request:
//    csb=~fire; web=~(fire&req_we); addr/din/wmask pass through (wmask forced 0 on reads).
//  - credits: cnt = in-flight reads + FIFO occupancy; never exceeds RSP_DEPTH.
//    req_ready = ~rst & (req_we | cnt < RSP_DEPTH | (cnt==RSP_DEPTH & rsp_pop_this_cycle)).
//    Writes are always accepted (req_ready=1 outside reset) and never consume credit.
//  - in-flight tracking: READ_LAT-bit shift register, bit0 set on read fire; at bit
//    READ_LAT-1 reaching a posedge, dout pushed into FIFO. Read data order = issue order.
//  - FIFO: push and pop in same cycle allowed at any occupancy, occupancy unchanged;
//    pop only when rsp_valid&rsp_ready. rsp_rdata = head entry, stable while not popped.
//  - cnt update: +1 on read fire, -1 on pop, both -> unchanged. cnt width clog2(RSP_DEPTH+1).
//  - read after write to same addr on next cycle returns new data (macro is serial; no
//    forwarding logic in this block). Write and read never issue in one cycle (1 port).
//  - reset (any cycle, incl. mid-burst): cnt=0, shift reg=0, FIFO empty, rsp_valid=0,
//    req_ready=0, csb=1, web=1; in-flight read data discarded, not pushed.
//  - rsp_rdata is don't-care when rsp_valid=0; bench must not compare it.
// TESTING
//  1. Reset held 5 cycles with req_valid=1 -> csb=1, web=1, req_ready=0, rsp_valid=0.
//  2. Write addr 0x005 data 0xDEADBEEF wmask 4'hF, then read 0x005 -> one rsp 0xDEADBEEF
//     READ_LAT+1 cycles after read fire; no rsp for the write.
//  3. Partial write 0x005 data 0x11223344 wmask 4'b0101 over case 2 -> read gives 0xDE22BE44.
//  4. rsp_ready=0, issue 4 back-to-back reads -> exactly RSP_DEPTH(2) accepted, req_ready
//     low after; raise rsp_ready -> remaining 2 accepted, 4 responses in order.
//  5. Full FIFO with rsp_ready=1 and read pending -> push+pop same cycle, no stall/bubble;
//     writes interleaved still accepted while credits exhausted.
//  6. Assert rst one cycle after a read fires -> no rsp_valid after reset; next read
//     returns correct data; golden-model random 1000-cycle run, all responses match.

Source files
------------

// File: rtl/sram_req_adapter.sv
// Valid/ready request front-end for a single-port 1rw SRAM macro. Read data is
// tracked across the macro latency and queued in a credit-protected response FIFO.
module sram_req_adapter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_WMASKS = 4,
  parameter int READ_LAT   = 1,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  csb,
  output logic                  web,
  output logic [NUM_WMASKS-1:0] wmask,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] dout
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(RSP_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(RSP_DEPTH - 1);

  logic [CW-1:0]         cnt;
  logic [CW-1:0]         occ;
  logic [READ_LAT-1:0]   pend;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
  logic                  fire;
  logic                  rd_fire;
  logic                  push;
  logic                  pop;

  assign rsp_valid = (occ != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign push      = pend[READ_LAT-1];
  assign rsp_rdata = fifo_q[rd_ptr];

  // A read may take the last credit back in the same cycle the consumer frees one.
  assign req_ready = ~rst & (req_we | (cnt < DEPTH_C) | ((cnt == DEPTH_C) & pop));
  assign fire      = req_valid & req_ready;
  assign rd_fire   = fire & ~req_we;

  assign csb   = ~fire;
  assign web   = ~(fire & req_we);
  assign addr  = req_addr;
  assign din   = req_wdata;
  assign wmask = req_we ? req_wmask : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      occ    <= '0;
      pend   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      pend <= (pend << 1) | READ_LAT'(rd_fire);

      case ({rd_fire, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase

      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase

      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push & ~rst) fifo_q[wr_ptr] <= dout;
  end

endmodule

// File: tb/tb_sram_req_adapter.sv
// Directed and random checks of sram_req_adapter against a behavioural SRAM
// macro and a request-side shadow memory scoreboard.
module tb_sram_req_adapter;
  localparam int DW = 32;
  localparam int AW = 9;
  localparam int NM = 4;
  localparam int RL = 1;
  localparam int RD = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [NM-1:0] req_wmask;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          csb, web;
  logic [NM-1:0] wmask;
  logic [AW-1:0] addr;
  logic [DW-1:0] din, dout;

  always #5 clk = ~clk;

  sram_req_adapter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NM), .READ_LAT(RL), .RSP_DEPTH(RD)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_wmask(req_wmask), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .csb(csb), .web(web), .wmask(wmask), .addr(addr), .din(din), .dout(dout)
  );

  // Behavioural macro: captures on posedge, data valid RL posedges later.
  logic [DW-1:0] sram    [512];
  logic [DW-1:0] rd_pipe [RL];

  initial for (int i = 0; i < 512; i++) sram[i] <= '0;

  always @(posedge clk) begin
    if (!csb) begin
      if (!web) begin
        for (int b = 0; b < NM; b++)
          if (wmask[b]) sram[addr][8*b +: 8] <= din[8*b +: 8];
      end else begin
        rd_pipe[0] <= sram[addr];
      end
    end
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign dout = rd_pipe[RL-1];

  int total = 0;
  int bad = 0;
  int rsp_cnt = 0;
  logic [DW-1:0] shadow [512];
  logic [DW-1:0] exp_q [$];

  initial for (int i = 0; i < 512; i++) shadow[i] = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: predicts read data at request time, checks it at pop time.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        check("rsp_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("rsp_data", rsp_rdata, exp_q.pop_front());
        rsp_cnt++;
      end
      if (req_valid && req_ready) begin
        if (req_we) begin
          for (int b = 0; b < NM; b++)
            if (req_wmask[b]) shadow[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
        end else begin
          exp_q.push_back(shadow[req_addr]);
        end
      end
    end
  end

  task automatic start();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [NM-1:0] m);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_wmask = m;
  endtask

  // Called right after the negedge of the read-fire cycle.
  task automatic wait_rsp(input string tag, input logic [DW-1:0] exp_data);
    int n = 0;
    do begin
      start();
      req_valid = 1'b0;
      n++;
      @(negedge clk);
    end while (!rsp_valid && n < 10);
    check({tag, "_latency"}, n, RL + 1);
    check({tag, "_valid"}, rsp_valid, 1);
    if (rsp_valid) check({tag, "_data"}, rsp_rdata, exp_data);
    start();
    @(negedge clk);
    check({tag, "_single"}, rsp_valid, 0);
  endtask

  task automatic issue_reads(input int n, input int max_cyc, input int off, input logic rr,
                             output int acc, output int cyc);
    acc = 0;
    cyc = 0;
    while (acc < n && cyc < max_cyc) begin
      start();
      rsp_ready = rr;
      drive(1'b1, 1'b0, 9'h10 + 9'((acc + off) % 4), '0, '0);
      @(negedge clk);
      if (req_ready) acc++;
      cyc++;
    end
  endtask

  task automatic drain(input string tag, input int expect_n, input int base);
    for (int i = 0; i < 12; i++) begin
      start();
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    check(tag, rsp_cnt - base, expect_n);
    @(negedge clk);
    check({tag, "_empty"}, rsp_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, cyc, base;

    rst = 1'b1;
    rsp_ready = 1'b1;
    drive(1'b1, 1'b0, 9'h005, '0, '0);
    for (int i = 0; i < 5; i++) begin
      start();
      @(negedge clk);
      check("rst_csb", csb, 1);
      check("rst_web", web, 1);
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
    end
    start();
    rst = 1'b0;
    req_valid = 1'b0;

    // full write then read back
    start();
    drive(1'b1, 1'b1, 9'h005, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    check("t2_wr_ready", req_ready, 1);
    check("t2_wr_csb", csb, 0);
    check("t2_wr_web", web, 0);
    check("t2_wr_wmask", wmask, 4'hF);
    start();
    drive(1'b1, 1'b0, 9'h005, 32'h0, 4'hF);
    @(negedge clk);
    check("t2_rd_ready", req_ready, 1);
    check("t2_rd_web", web, 1);
    check("t2_rd_wmask", wmask, 4'h0);
    check("t2_no_wr_rsp", rsp_valid, 0);
    wait_rsp("t2", 32'hDEADBEEF);

    // partial byte write over the previous word
    start();
    drive(1'b1, 1'b1, 9'h005, 32'h11223344, 4'b0101);
    @(negedge clk);
    check("t3_wr_wmask", wmask, 4'b0101);
    start();
    drive(1'b1, 1'b0, 9'h005, '0, '0);
    @(negedge clk);
    wait_rsp("t3", 32'hDE22BE44);

    for (int i = 0; i < 4; i++) begin
      start();
      drive(1'b1, 1'b1, 9'h10 + 9'(i), 32'hA0000000 + 32'(i), 4'hF);
    end
    start();
    req_valid = 1'b0;

    // credit exhaustion with a stalled consumer
    base = rsp_cnt;
    issue_reads(4, 6, 0, 1'b0, acc, cyc);
    check("t4_stalled_accepts", acc, RD);
    check("t4_ready_low", req_ready, 0);
    check("t4_fifo_valid", rsp_valid, 1);
    issue_reads(2, 10, 2, 1'b1, acc, cyc);
    check("t4_resume_accepts", acc, 2);
    check("t4_resume_cycles", cyc, 2);
    drain("t4_rsp_count", 4, base);

    // full FIFO, interleaved write, then streaming push+pop
    base = rsp_cnt;
    issue_reads(2, 4, 0, 1'b0, acc, cyc);
    check("t5_fill", acc, 2);
    start();
    req_valid = 1'b0;
    start();
    drive(1'b1, 1'b0, 9'h012, '0, '0);
    @(negedge clk);
    check("t5_read_blocked", req_ready, 0);
    start();
    drive(1'b1, 1'b1, 9'h020, 32'h5A5A5A5A, 4'hF);
    @(negedge clk);
    check("t5_write_ready", req_ready, 1);
    check("t5_write_csb", csb, 0);
    check("t5_write_web", web, 0);
    issue_reads(6, 12, 2, 1'b1, acc, cyc);
    check("t5_stream_accepts", acc, 6);
    check("t5_stream_cycles", cyc, 6);
    start();
    drive(1'b1, 1'b0, 9'h020, '0, '0);
    @(negedge clk);
    check("t5_rd20_ready", req_ready, 1);
    drain("t5_rsp_count", 9, base);

    // reset one cycle after a read fires
    start();
    drive(1'b1, 1'b0, 9'h005, '0, '0);
    @(negedge clk);
    check("t6_rd_ready", req_ready, 1);
    start();
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_ready", req_ready, 0);
    check("t6_rst_csb", csb, 1);
    start();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_no_rsp", rsp_valid, 0);
      start();
    end
    drive(1'b1, 1'b0, 9'h005, '0, '0);
    @(negedge clk);
    wait_rsp("t6", 32'hDE22BE44);

    // random traffic against the scoreboard
    for (int i = 0; i < 1000; i++) begin
      start();
      rsp_ready = ($urandom_range(0, 3) != 0);
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), 9'($urandom_range(0, 15)),
            $urandom, 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 12; i++) begin
      start();
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    check("rand_all_returned", exp_q.size(), 0);
    @(negedge clk);
    check("rand_idle_valid", rsp_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
